// File: rtl/mult_err_pkg.sv
// Shared constants and FSM state type for the approximate-multiplier error monitor.
package mult_err_pkg;

   localparam int unsigned OP_W   = 8;
   localparam int unsigned PROD_W = 16;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain,
      StDone
   } state_e;

endpackage

// File: rtl/mult_8x8_exact.sv
// Exact 8x8 unsigned multiplier; reference product for the error monitor.
module mult_8x8_exact
   import mult_err_pkg::*;
(
   input  logic [OP_W-1:0]   A,
   input  logic [OP_W-1:0]   B,
   output logic [PROD_W-1:0] R
);

   assign R = PROD_W'(A) * PROD_W'(B);

endmodule

// File: rtl/mult_err_monitor.sv
// Measures error distance of an approximate 8x8 multiplier over a window of
// 2^WINDOW_LOG2 accepted samples. Optional signed bias sum: ERR_MON_BIAS_EN.
module mult_err_monitor
   import mult_err_pkg::*;
#(
   parameter int unsigned WINDOW_LOG2 = 8,
   parameter int unsigned ACC_W       = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [OP_W-1:0]        a,
   input  logic [OP_W-1:0]        b,
   input  logic [PROD_W-1:0]      r_approx,
   output logic                   busy,
   output logic                   done,
   output logic [WINDOW_LOG2:0]   err_count,
   output logic [ACC_W-1:0]       sum_ed,
   output logic [PROD_W-1:0]      max_ed
`ifdef ERR_MON_BIAS_EN
   ,
   output logic signed [ACC_W-1:0] sum_bias
`endif
);

   state_e                 state_q, state_d;
   logic [WINDOW_LOG2-1:0] acc_cnt_q;
   logic                   drain_q;
   logic                   done_q;

   logic                   s1_valid_q;
   logic [PROD_W-1:0]      s1_exact_q;
   logic [PROD_W-1:0]      s1_approx_q;

   logic [WINDOW_LOG2:0]   err_count_q;
   logic [ACC_W-1:0]       sum_ed_q;
   logic [PROD_W-1:0]      max_ed_q;

   logic                   accept;
   logic                   last_accept;
   logic                   clear;
   logic [PROD_W-1:0]      exact;
   logic [PROD_W-1:0]      ed;
   logic [ACC_W:0]         sum_wide;
   logic [ACC_W-1:0]       sum_sat;

   mult_8x8_exact u_exact (
      .A (a),
      .B (b),
      .R (exact)
   );

   assign in_ready    = (state_q == StRun);
   assign busy        = (state_q == StRun) || (state_q == StDrain);
   assign accept      = in_valid && in_ready;
   assign last_accept = accept && (acc_cnt_q == '1);
   assign clear       = start && ((state_q == StIdle) || (state_q == StDone));

   // Next-state decode; start is only honoured outside an active window.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StDone: if (start) state_d = StRun;
         StRun:          if (last_accept) state_d = StDrain;
         StDrain:        if (drain_q) state_d = StDone;
         default:        state_d = StIdle;
      endcase
   end

   // Control state: FSM, window sample counter and the two-cycle drain timer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         acc_cnt_q <= '0;
         drain_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         // Drain covers the two pipeline stages behind the final acceptance.
         drain_q <= (state_q == StDrain) && !drain_q;
         done_q  <= (state_q == StDrain) && drain_q;
         if (clear) begin
            acc_cnt_q <= '0;
         end else if (accept) begin
            acc_cnt_q <= acc_cnt_q + WINDOW_LOG2'(1);
         end
      end
   end

   // Stage 1: capture exact product and approximate result of each accepted sample.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_exact_q  <= '0;
         s1_approx_q <= '0;
      end else begin
         s1_valid_q <= accept;
         if (accept) begin
            s1_exact_q  <= exact;
            s1_approx_q <= r_approx;
         end
      end
   end

   // Stage 2 datapath: absolute error distance and saturating sum.
   always_comb begin
      ed       = (s1_exact_q >= s1_approx_q) ? (s1_exact_q - s1_approx_q)
                                             : (s1_approx_q - s1_exact_q);
      sum_wide = {1'b0, sum_ed_q} + {{(ACC_W - PROD_W + 1){1'b0}}, ed};
      sum_sat  = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
   end

   // Stage 2 accumulators; cleared by an accepted start, frozen in DONE.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         err_count_q <= '0;
         sum_ed_q    <= '0;
         max_ed_q    <= '0;
      end else if (s1_valid_q) begin
         sum_ed_q <= sum_sat;
         if (ed > max_ed_q) max_ed_q <= ed;
         if (ed != '0) err_count_q <= err_count_q + (WINDOW_LOG2 + 1)'(1);
      end
   end

   assign done      = done_q;
   assign err_count = err_count_q;
   assign sum_ed    = sum_ed_q;
   assign max_ed    = max_ed_q;

`ifdef ERR_MON_BIAS_EN
   logic signed [ACC_W-1:0] sum_bias_q;
   logic signed [PROD_W:0]  diff;
   logic signed [ACC_W:0]   bias_wide;
   logic signed [ACC_W-1:0] bias_sat;

   // Signed bias r_approx - exact, clamped at both ends of the accumulator range.
   always_comb begin
      diff      = $signed({1'b0, s1_approx_q}) - $signed({1'b0, s1_exact_q});
      bias_wide = (ACC_W + 1)'(sum_bias_q) + (ACC_W + 1)'(diff);
      if (bias_wide[ACC_W] != bias_wide[ACC_W-1]) begin
         bias_sat = {bias_wide[ACC_W], {(ACC_W - 1){~bias_wide[ACC_W]}}};
      end else begin
         bias_sat = bias_wide[ACC_W-1:0];
      end
   end

   // Bias accumulator shares the clear/update timing of the error accumulators.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         sum_bias_q <= '0;
      end else if (s1_valid_q) begin
         sum_bias_q <= bias_sat;
      end
   end

   assign sum_bias = sum_bias_q;
`endif

endmodule

// File: tb/tb_mult_err_monitor.sv
// Self-checking bench for mult_err_monitor with randomized windows and a
// behavioural model of the window statistics. Define ERR_MON_BIAS_EN to cover sum_bias.
module tb_mult_err_monitor;

   localparam int unsigned WL  = 8;
   localparam int unsigned AW  = 16;
   localparam int          WIN = 1 << WL;
   localparam longint      SAT      = (longint'(1) << AW) - 1;
   localparam longint      BIAS_MAX = (longint'(1) << (AW - 1)) - 1;
   localparam longint      BIAS_MIN = -(longint'(1) << (AW - 1));

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [7:0]    a = '0;
   logic [7:0]    b = '0;
   logic [15:0]   r_approx = '0;
   logic          busy;
   logic          done;
   logic [WL:0]   err_count;
   logic [AW-1:0] sum_ed;
   logic [15:0]   max_ed;
`ifdef ERR_MON_BIAS_EN
   logic signed [AW-1:0] sum_bias;
`endif

   int vectors = 0;
   int miscompares = 0;

   int     exp_cnt;
   longint exp_sum;
   longint exp_max;
   longint exp_bias;

   mult_err_monitor #(
      .WINDOW_LOG2 (WL),
      .ACC_W       (AW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .r_approx  (r_approx),
      .busy      (busy),
      .done      (done),
      .err_count (err_count),
      .sum_ed    (sum_ed),
      .max_ed    (max_ed)
`ifdef ERR_MON_BIAS_EN
      ,
      .sum_bias  (sum_bias)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_clear();
      exp_cnt  = 0;
      exp_sum  = 0;
      exp_max  = 0;
      exp_bias = 0;
   endtask

   task automatic model_add(input int ea, input int eb, input int er);
      int ex, ed;
      ex = ea * eb;
      ed = (ex > er) ? ex - er : er - ex;
      if (ed != 0) exp_cnt++;
      if (ed > exp_max) exp_max = ed;
      exp_sum = exp_sum + ed;
      if (exp_sum > SAT) exp_sum = SAT;
      exp_bias = exp_bias + er - ex;
      if (exp_bias > BIAS_MAX) exp_bias = BIAS_MAX;
      if (exp_bias < BIAS_MIN) exp_bias = BIAS_MIN;
   endtask

   task automatic pick(input int mode, output int ea, output int eb, output int er);
      int d;
      ea = $urandom_range(0, 255);
      eb = $urandom_range(0, 255);
      case (mode)
         0: er = ea * eb;
         1: begin ea = 15; eb = 15; er = 200; end
         2: begin ea = 255; eb = 255; er = 0; end
         3: begin
            d  = $urandom_range(0, 40) - 20;
            er = ea * eb + d;
            if (er < 0) er = 0;
            if (er > 65535) er = 65535;
         end
         4: er = ea * eb + 3;
         default: begin
            ea = $urandom_range(2, 255);
            eb = $urandom_range(2, 255);
            er = ea * eb - 3;
         end
      endcase
   endtask

   // Runs one full window. stalls: 0 none, 1 toggling valid, 2 random valid.
   task automatic run_window(input int mode, input int stalls);
      int n, cyc, lat, ea, eb, er;
      bit v;
      model_clear();
      @(negedge clk);
      start = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
      vectors++;
      if (busy !== 1'b1 || sum_ed !== '0 || err_count !== '0 || max_ed !== '0) begin
         miscompares++;
         $display("FAIL window_clear: busy=%0b sum=%0d cnt=%0d max=%0d, need busy=1 and zeros",
                  busy, sum_ed, err_count, max_ed);
      end
      n = 0;
      cyc = 0;
      while (n < WIN && cyc < 4000) begin
         v = (stalls == 0) ? 1'b1 : (stalls == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
         pick(mode, ea, eb, er);
         a = 8'(ea);
         b = 8'(eb);
         r_approx = 16'(er);
         in_valid = v;
         // A start mid-window must be ignored.
         start = (cyc == 60);
         vectors++;
         if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL in_ready_run: got %0b at sample %0d, need 1", in_ready, n);
         end
         if (v) begin
            model_add(ea, eb, er);
            n++;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      in_valid = 1'b0;
      vectors++;
      if (n != WIN || in_ready !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL drain_entry: accepted=%0d ready=%0b busy=%0b, need %0d/0/1",
                  n, in_ready, busy, WIN);
      end
      lat = 0;
      while (done !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      vectors++;
      if (lat != 2) begin
         miscompares++;
         $display("FAIL done_latency: got %0d cycles, need 2", lat);
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL busy_done: got %0b, need 0", busy);
      end
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (int'(err_count) != exp_cnt || longint'(sum_ed) != exp_sum ||
             longint'(max_ed) != exp_max) begin
            miscompares++;
            $display("FAIL results[%0d]: cnt=%0d sum=%0d max=%0d, need cnt=%0d sum=%0d max=%0d",
                     k, err_count, sum_ed, max_ed, exp_cnt, exp_sum, exp_max);
         end
`ifdef ERR_MON_BIAS_EN
         vectors++;
         if (longint'(sum_bias) != exp_bias) begin
            miscompares++;
            $display("FAIL bias[%0d]: got %0d, need %0d", k, sum_bias, exp_bias);
         end
`endif
         @(negedge clk);
         vectors++;
         if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse: done still %0b %0d cycles later, need 0", done, k + 1);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err_count !== '0 ||
          sum_ed !== '0 || max_ed !== '0) begin
         miscompares++;
         $display("FAIL reset_state: ready=%0b busy=%0b done=%0b cnt=%0d sum=%0d max=%0d, need 0",
                  in_ready, busy, done, err_count, sum_ed, max_ed);
      end
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_after_reset: ready=%0b busy=%0b, need 0", in_ready, busy);
      end
   endtask

   task automatic test_exact();
      run_window(0, 0);
      vectors++;
      if (err_count !== '0 || sum_ed !== '0 || max_ed !== '0) begin
         miscompares++;
         $display("FAIL exact_case: cnt=%0d sum=%0d max=%0d, need 0", err_count, sum_ed, max_ed);
      end
   endtask

   task automatic test_const_error(input int stalls);
      run_window(1, stalls);
      vectors++;
      if (sum_ed !== AW'(6400) || max_ed !== 16'd25 || err_count !== (WL + 1)'(256)) begin
         miscompares++;
         $display("FAIL const_error(stall=%0d): sum=%0d max=%0d cnt=%0d, need 6400/25/256",
                  stalls, sum_ed, max_ed, err_count);
      end
   endtask

   task automatic test_saturation();
      run_window(2, 0);
      vectors++;
      if (sum_ed !== AW'(65535) || max_ed !== 16'd65025) begin
         miscompares++;
         $display("FAIL saturation: sum=%0d max=%0d, need 65535/65025", sum_ed, max_ed);
      end
   endtask

   task automatic test_back_to_back();
      run_window(3, 2);
      run_window(3, 0);
   endtask

   task automatic test_reset_mid_run();
      int ea, eb, er;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 100; i++) begin
         pick(1, ea, eb, er);
         a = 8'(ea);
         b = 8'(eb);
         r_approx = 16'(er);
         in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || err_count !== '0 ||
          sum_ed !== '0 || max_ed !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_run: busy=%0b ready=%0b done=%0b cnt=%0d sum=%0d max=%0d, need 0",
                  busy, in_ready, done, err_count, sum_ed, max_ed);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         vectors++;
         if (done !== 1'b0 || busy !== 1'b0 || sum_ed !== '0) begin
            miscompares++;
            $display("FAIL no_done_after_reset[%0d]: done=%0b busy=%0b sum=%0d, need 0",
                     k, done, busy, sum_ed);
         end
      end
   endtask

`ifdef ERR_MON_BIAS_EN
   task automatic test_bias();
      run_window(4, 0);
      vectors++;
      if (sum_bias !== AW'(768) || sum_ed !== AW'(768)) begin
         miscompares++;
         $display("FAIL bias_plus3: bias=%0d sum=%0d, need 768/768", sum_bias, sum_ed);
      end
      run_window(5, 1);
      vectors++;
      if (longint'(sum_bias) != -768 || sum_ed !== AW'(768)) begin
         miscompares++;
         $display("FAIL bias_minus3: bias=%0d sum=%0d, need -768/768", sum_bias, sum_ed);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_exact();
      test_const_error(0);
      test_const_error(1);
      test_saturation();
      test_back_to_back();
      test_reset_mid_run();
`ifdef ERR_MON_BIAS_EN
      test_bias();
`endif
      test_const_error(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mult_err_monitor.md
MULT_ERR_MONITOR -- requirements
Module: mult_err_monitor

Interface
REQ-001 Parameter WINDOW_LOG2, default 8, meaning window length = 2^WINDOW_LOG2 samples.
REQ-002 Parameter ACC_W, default 32, meaning width of the error-distance accumulator, minimum 16.
REQ-003 clk  input  1  meaning the only clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  meaning reset, synchronous and active-low.
REQ-005 start  input  1  meaning one-cycle pulse that opens a new measurement window.
REQ-006 in_valid  input  1  meaning a, b and r_approx carry a sample.
REQ-007 in_ready  output  1  meaning the block accepts a sample this cycle.
REQ-008 a, b  input  8 each  meaning multiplier operands fed to the approximate 8x8 multiplier.
REQ-009 r_approx  input  16  meaning the approximate multiplier's product for a, b.
REQ-010 busy  output  1  meaning a window is in progress.
REQ-011 done  output  1  meaning one-cycle pulse; all result outputs are final.
REQ-012 err_count  output  WINDOW_LOG2+1  meaning number of samples with nonzero error.
REQ-013 sum_ed  output  ACC_W  meaning saturating sum of |a*b - r_approx|.
REQ-014 max_ed  output  16  meaning largest |a*b - r_approx| seen in the window.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-016 On start in IDLE or DONE, the block SHALL clear all accumulators and enter RUN on the next edge; start in RUN or DRAIN SHALL be ignored.
REQ-017 in_ready SHALL be 1 only in RUN; a sample SHALL be accepted when in_valid and in_ready are both 1.
REQ-018 Stage 1 SHALL register the exact 16-bit product a*b, r_approx and a valid bit on each accepted sample.
REQ-019 Stage 2 SHALL compute ed = |exact - r_approx| (16 bits, unsigned), add it to sum_ed, update max_ed, and increment err_count when ed != 0.
REQ-020 sum_ed SHALL saturate at 2^ACC_W-1 and not wrap.
REQ-021 After the 2^WINDOW_LOG2-th acceptance, in_ready SHALL drop on the same edge and the FSM SHALL enter DRAIN.
REQ-022 done SHALL assert exactly 2 cycles after the edge that accepted the final sample; the FSM SHALL then enter DONE.
REQ-023 In DONE, the results SHALL hold until the next start.
REQ-024 busy SHALL be 1 in RUN and DRAIN, and 0 otherwise.
REQ-025 Gaps in in_valid SHALL stall counting without affecting the result.

Reset
REQ-026 While rst_n is 0 at an edge, the FSM SHALL go to IDLE and all outputs, pipeline valids and accumulators SHALL become 0; in_ready SHALL be 0.
REQ-027 A reset during RUN or DRAIN SHALL discard the partial window and produce no done.

Configuration
REQ-028 With ERR_MON_BIAS_EN defined, the block SHALL add an output sum_bias (signed, ACC_W) holding the saturating sum of r_approx - exact, reset and cleared with the other accumulators.
REQ-029 Without ERR_MON_BIAS_EN, neither the sum_bias port nor its logic SHALL exist.

Structure
REQ-030 Package mult_err_pkg SHALL hold the FSM state enum and the constants OP_W=8 and PROD_W=16.
REQ-031 The exact product SHALL come from one combinational sub-module, mult_8x8_exact (A[7:0], B[7:0] -> R[15:0]).

Verification
REQ-032 Exact case: 256 samples with r_approx=a*b over random a, b -> err_count=0, sum_ed=0, max_ed=0, done once.
REQ-033 Constant error: a=15, b=15, r_approx=200, 256 samples -> sum_ed=6400, max_ed=25, err_count=256.
REQ-034 Stalls: the same stimulus as REQ-033 with in_valid toggling 1/0 -> identical results, and done 2 cycles after the last acceptance.
REQ-035 Saturation: ACC_W=16, a=b=255, r_approx=0, 256 samples -> sum_ed=65535, max_ed=65025.
REQ-036 Reset after 100 accepted samples in RUN -> next cycle IDLE, all outputs 0, no done.
REQ-037 ERR_MON_BIAS_EN defined: r_approx=exact+3 for 256 samples -> sum_bias=+768; r_approx=exact-3 -> sum_bias=-768, with sum_ed=768 in both cases.
